// File: rtl/mcpu_mem_port_pkg.sv
// Shared types and constants for the multi-cycle CPU memory-access stage.
package mcpu_mem_port_pkg;

    // Memory port FSM: waiting for a controller strobe, or holding a bus request
    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam int DATA_W      = 32;
    localparam int TIMER_W     = 8;
    localparam int TIMEOUT_DEF = 255;

    // Instruction register field positions (MIPS encoding)
    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    // Opcodes the controller decodes from o_opcode
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Word accesses only: the two low byte-address bits must be zero
    function automatic logic addr_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for a memory acknowledge; flags the abort point.
module mem_wait_timer
    import mcpu_mem_port_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam logic [TIMER_W-1:0] TC_VALUE = TIMER_W'(TIMEOUT);

    logic [TIMER_W-1:0] r_count;

    // Clear while idle, count while waiting, hold at terminal count so it never wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_tc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == TC_VALUE);

endmodule

// File: rtl/mcpu_mem_port.sv
// Memory-access stage: runs one req/ack bus transaction per controller strobe,
// loads IR or MDR, stalls the controller while waiting, and decodes IR fields.
module mcpu_mem_port
    import mcpu_mem_port_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_ir_write,
    input  logic              i_iord,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_alu_out,
    input  logic [DATA_W-1:0] i_store_data,
    output logic              o_stall,
    output logic [DATA_W-1:0] o_ir,
    output logic [5:0]        o_opcode,
    output logic [5:0]        o_funct,
    output logic [4:0]        o_rs,
    output logic [4:0]        o_rt,
    output logic [4:0]        o_rd,
    output logic [4:0]        o_shamt,
    output logic [15:0]       o_imm16,
    output logic [DATA_W-1:0] o_mdr,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    output logic              o_bus_err,
    output logic              o_align_err,
    output state_t            o_state
);

    // Bus handshake: o_mem_req rises with o_mem_we/o_mem_addr/o_mem_wdata valid and
    // holds them stable until the cycle i_mem_ack pulses (or the wait times out);
    // o_mem_req falls on the edge that samples the ack.

    state_t            r_state;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_mdr;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_dst_ir;
    logic              r_bus_err;
    logic              r_align_err;

    logic              w_start;
    logic [ADDR_W-1:0] w_addr;
    logic              w_aligned;
    logic              w_tc;

    assign w_start   = i_mem_read | i_mem_write;
    assign w_addr    = i_iord ? i_alu_out : i_pc;
    assign w_aligned = addr_aligned(w_addr[1:0]);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (r_state == S_IDLE),
        .i_enable (r_state == S_BUSY),
        .o_tc     (w_tc)
    );

    // Stall is forced low during reset so a held strobe cannot freeze the controller
    assign o_stall = ~reset &
                     (((r_state == S_IDLE) & w_start & w_aligned) |
                      ((r_state == S_BUSY) & ~i_mem_ack & ~w_tc));

    // Transaction FSM with the IR/MDR and bus request registers it owns
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ir        <= '0;
            r_mdr       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_dst_ir    <= 1'b0;
            r_bus_err   <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        if (w_aligned) begin
                            r_mem_addr  <= w_addr;
                            r_mem_we    <= i_mem_write;
                            r_mem_wdata <= i_store_data;
                            r_dst_ir    <= i_ir_write & ~i_mem_write;
                            r_mem_req   <= 1'b1;
                            r_state     <= S_BUSY;
                        end else begin
                            // Misaligned: no bus cycle; a read delivers a zero word
                            r_align_err <= 1'b1;
                            if (!i_mem_write) begin
                                if (i_ir_write) r_ir  <= '0;
                                else            r_mdr <= '0;
                            end
                        end
                    end
                end
                S_BUSY: begin
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            if (r_dst_ir) r_ir  <= i_mem_rdata;
                            else          r_mdr <= i_mem_rdata;
                        end
                        r_state <= S_IDLE;
                    end else if (w_tc) begin
                        // Abort: a timed-out read yields zero, which decodes as a nop
                        r_mem_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        if (!r_mem_we) begin
                            if (r_dst_ir) r_ir  <= '0;
                            else          r_mdr <= '0;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ir        = r_ir;
    assign o_mdr       = r_mdr;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_bus_err   = r_bus_err;
    assign o_align_err = r_align_err;
    assign o_state     = r_state;

    assign o_opcode = r_ir[OPC_HI:OPC_LO];
    assign o_rs     = r_ir[RS_HI:RS_LO];
    assign o_rt     = r_ir[RT_HI:RT_LO];
    assign o_rd     = r_ir[RD_HI:RD_LO];
    assign o_shamt  = r_ir[SHAMT_HI:SHAMT_LO];
    assign o_funct  = r_ir[FUNCT_HI:FUNCT_LO];
    assign o_imm16  = r_ir[IMM_HI:IMM_LO];

endmodule
